// File: rtl/stopwatch_pkg.sv
// Shared constants for the M:SS stopwatch: FSM encoding, 1 Hz divider
// terminal count and the decimal moduli of the three digits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [25:0] TICK_MAX_1HZ = 26'd49_999_999;

    localparam int SEC_ONES_MOD = 10;
    localparam int SEC_TENS_MOD = 6;
    localparam int MIN_ONES_MOD = 10;

endpackage

// File: rtl/stopwatch_mod_n_digit.sv
// One decimal digit of the stopwatch: counts 0..N-1 on en, clr has priority.
module mod_n_digit #(
    parameter int N = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    localparam logic [3:0] LAST = 4'(N - 1);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = (q_q == LAST) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == LAST);

endmodule

// File: rtl/stopwatch_controller.sv
// M:SS stopwatch: start/pause/clear FSM gating a rate divider whose terminal
// count ticks three cascaded decimal digits.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int               DIV_W    = 26,
    parameter logic [DIV_W-1:0] TICK_MAX = DIV_W'(TICK_MAX_1HZ)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_stop_n,
    input  logic       clear_n,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       tick,
    output logic       wrapped
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ss_prev_q, clr_prev_q;
    logic             tick_q, tick_d;
    logic             wrapped_q, wrapped_d;
    logic             running_q, running_d;

    logic press_ss, press_clr;
    logic term_cnt, tick_en, digit_clr;
    logic ones_carry, tens_carry, mins_carry;

    // Edge detect on the active-low buttons so a held press is one event.
    assign press_ss  = ss_prev_q & ~start_stop_n;
    assign press_clr = clr_prev_q & ~clear_n;

    assign term_cnt  = (state_q == ST_RUN) && (div_q == TICK_MAX);
    assign tick_en   = term_cnt & ~press_clr;
    assign digit_clr = ((state_q != ST_RUN) && (state_q != ST_PAUSE)) | press_clr;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tick_d    = tick_en;
        wrapped_d = mins_carry;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (!press_clr && press_ss) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                div_d = term_cnt ? '0 : div_q + DIV_W'(1);
                if (press_clr) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (press_ss) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press_clr) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (press_ss) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            ss_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
            tick_q     <= 1'b0;
            wrapped_q  <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            ss_prev_q  <= start_stop_n;
            clr_prev_q <= clear_n;
            tick_q     <= tick_d;
            wrapped_q  <= wrapped_d;
            running_q  <= running_d;
        end
    end

    mod_n_digit #(.N(SEC_ONES_MOD)) u_sec_ones (
        .clock (clock),
        .reset (reset),
        .clr   (digit_clr),
        .en    (tick_en),
        .q     (sec_ones),
        .carry (ones_carry)
    );

    mod_n_digit #(.N(SEC_TENS_MOD)) u_sec_tens (
        .clock (clock),
        .reset (reset),
        .clr   (digit_clr),
        .en    (ones_carry),
        .q     (sec_tens),
        .carry (tens_carry)
    );

    mod_n_digit #(.N(MIN_ONES_MOD)) u_min_ones (
        .clock (clock),
        .reset (reset),
        .clr   (digit_clr),
        .en    (tens_carry),
        .q     (min_ones),
        .carry (mins_carry)
    );

    assign running = running_q;
    assign tick    = tick_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with TICK_MAX=3 (4-cycle tick):
// a per-cycle vector table plus hand sequences for pause, wrap, clear and reset.
module tb_stopwatch_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_stop_n;
    logic       clear_n;
    logic [3:0] sec_ones, sec_tens, min_ones;
    logic       running, tick, wrapped;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        rst_n;
        logic        ss_n;
        logic        clr_n;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    stopwatch_controller #(.DIV_W(26), .TICK_MAX(26'd3)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_stop_n (start_stop_n),
        .clear_n      (clear_n),
        .sec_ones     (sec_ones),
        .sec_tens     (sec_tens),
        .min_ones     (min_ones),
        .running      (running),
        .tick         (tick),
        .wrapped      (wrapped)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] pk(input logic r, input logic t, input logic w,
                                       input int mo, input int st, input int so);
        return {r, t, w, 4'(mo), 4'(st), 4'(so)};
    endfunction

    function automatic logic [14:0] outs();
        return {running, tick, wrapped, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic s, input logic c, input logic [14:0] e);
        vec_t v;
        v.rst_n = r;
        v.ss_n  = s;
        v.clr_n = c;
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        start_stop_n = 1'b1;
        clear_n      = 1'b1;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    task automatic press_ss();
        start_stop_n = 1'b0;
        cyc();
        start_stop_n = 1'b1;
    endtask

    task automatic run_until_tick(input string name, input int bound);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!tick && n < bound);
        check(name, 32'(tick), 32'd1);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("reset_outputs", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));

        // Vector table: start held 20 cycles, pause/resume, clear in RUN,
        // held clear with start, mid-run reset, restart.
        for (int k = 1; k <= 20; k++) begin
            add_vec(1, 0, 1, pk(1, (k >= 5 && (k - 1) % 4 == 0), 0, 0, 0, (k - 1) / 4));
        end
        add_vec(1, 1, 1, pk(1, 1, 0, 0, 0, 5));
        add_vec(1, 0, 1, pk(0, 0, 0, 0, 0, 5));
        for (int k = 0; k < 3; k++) add_vec(1, 1, 1, pk(0, 0, 0, 0, 0, 5));
        add_vec(1, 0, 1, pk(1, 0, 0, 0, 0, 5));
        add_vec(1, 1, 1, pk(1, 0, 0, 0, 0, 5));
        add_vec(1, 1, 1, pk(1, 0, 0, 0, 0, 5));
        add_vec(1, 1, 1, pk(1, 1, 0, 0, 0, 6));
        add_vec(1, 1, 0, pk(0, 0, 0, 0, 0, 0));
        add_vec(1, 0, 0, pk(1, 0, 0, 0, 0, 0));
        add_vec(1, 1, 1, pk(1, 0, 0, 0, 0, 0));
        add_vec(1, 1, 1, pk(1, 0, 0, 0, 0, 0));
        add_vec(0, 1, 1, pk(0, 0, 0, 0, 0, 0));
        add_vec(1, 1, 1, pk(0, 0, 0, 0, 0, 0));
        add_vec(1, 0, 1, pk(1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) add_vec(1, 1, 1, pk(1, 0, 0, 0, 0, 0));
        add_vec(1, 1, 1, pk(1, 1, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            reset        = vecs[i].rst_n;
            start_stop_n = vecs[i].ss_n;
            clear_n      = vecs[i].clr_n;
            cyc();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Pause after divider reaches 2: frozen 50 cycles, resume keeps partial second
        do_reset();
        press_ss();
        cyc();
        cyc();
        press_ss();
        check("pause_enter", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (k % 10 == 9) check($sformatf("pause_hold%0d", k), 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
        end
        press_ss();
        check("resume_first", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
        cyc();
        check("resume_tick", 32'(outs()), 32'(pk(1, 1, 0, 0, 0, 1)));

        // 40 RUN cycles -> 0:10, then on to 9:59 and the wrap
        do_reset();
        press_ss();
        for (int k = 0; k < 40; k++) cyc();
        check("run40", 32'(outs()), 32'(pk(1, 1, 0, 0, 1, 0)));
        for (int k = 0; k < 589; k++) run_until_tick("tick_to_959", 8);
        check("at_959", 32'(outs()), 32'(pk(1, 1, 0, 9, 5, 9)));
        run_until_tick("tick_wrap", 8);
        check("wrap", 32'(outs()), 32'(pk(1, 1, 1, 0, 0, 0)));
        cyc();
        check("wrap_pulse_end", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));

        // Start/stop and clear together at terminal count: clear wins
        do_reset();
        press_ss();
        run_until_tick("tc_pre1", 8);
        run_until_tick("tc_pre2", 8);
        cyc();
        cyc();
        cyc();
        start_stop_n = 1'b0;
        clear_n      = 1'b0;
        cyc();
        start_stop_n = 1'b1;
        clear_n      = 1'b1;
        check("both_at_tc", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
        cyc();
        check("both_after", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));

        // Start/stop alone at terminal count: tick honoured, then PAUSE
        do_reset();
        press_ss();
        run_until_tick("ss_tc_pre", 8);
        cyc();
        cyc();
        cyc();
        press_ss();
        check("ss_at_tc", 32'(outs()), 32'(pk(0, 1, 0, 0, 0, 2)));
        cyc();
        check("ss_at_tc_after", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 2)));
        // Resume from divider 0, then clear alone at terminal count
        press_ss();
        cyc();
        cyc();
        cyc();
        clear_n = 1'b0;
        cyc();
        clear_n = 1'b1;
        check("clr_at_tc", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));

        // Reset pulse while running at 3:27, then count again from 0:00
        do_reset();
        press_ss();
        for (int k = 0; k < 207; k++) run_until_tick("tick_to_327", 8);
        check("at_327", 32'(outs()), 32'(pk(1, 1, 0, 3, 2, 7)));
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        check("mid_reset", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
        cyc();
        check("post_reset_idle", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 0)));
        press_ss();
        check("restart", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
        cyc();
        cyc();
        cyc();
        cyc();
        check("restart_tick", 32'(outs()), 32'(pk(1, 1, 0, 0, 0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
